decode: RTL and testbench

Instruction decode stage: consumer end of the fetch-to-decode pipeline latch. Each cycle it takes the 64-bit `IF_ID` word ({pc, instruction}) from fetch, splits fields, reads a 32x32 register file, generates control signals, and registers the result into the ID/EX latch for execute. It owns the register file write port driven by writeback, and detects load-use hazards, stalling fetch for one cycle.

---
 rtl/decode_if.sv | 36 +++
 rtl/decode.sv | 120 ++++++++++++
 tb/tb_decode.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// rtl/decode_if.sv - decode stage bus: fetch latch and writeback port in, ID/EX latch out
// master = surrounding pipeline, slave = decode stage.
interface decode_if #(parameter int PC_W = 32);
   logic [PC_W+31:0] IF_ID;
   logic             if_valid;
   logic             flush;
   logic             wb_en;
   logic [4:0]       wb_addr;
   logic [31:0]      wb_data;
   logic             stall;
   logic             ex_valid;
   logic [PC_W-1:0]  ex_pc;
   logic [31:0]      ex_rs_data;
   logic [31:0]      ex_rt_data;
   logic [31:0]      ex_imm;
   logic [4:0]       ex_rt;
   logic [4:0]       ex_rd;
   logic [5:0]       ex_funct;
   logic [25:0]      ex_jtarget;
   logic             ex_reg_write, ex_mem_read, ex_mem_write;
   logic             ex_branch, ex_jump, ex_alu_src, ex_illegal;

   modport master (
      output IF_ID, if_valid, flush, wb_en, wb_addr, wb_data,
      input  stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rt, ex_rd,
             ex_funct, ex_jtarget, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_jump, ex_alu_src, ex_illegal
   );

   modport slave (
      input  IF_ID, if_valid, flush, wb_en, wb_addr, wb_data,
      output stall, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rt, ex_rd,
             ex_funct, ex_jtarget, ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_jump, ex_alu_src, ex_illegal
   );
endinterface

// File: rtl/decode.sv
// rtl/decode.sv - instruction decode stage: field split, 32x32 regfile, control, ID/EX latch
// Optional write-through forwarding of the writeback port: define DECODE_WB_BYPASS_EN.
module decode #(
   parameter int PC_W  = 32,
   parameter int NREGS = 32
) (
   input logic     clock,
   input logic     reset,
   decode_if.slave bus
);
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [31:0]     rs_data;
      logic [31:0]     rt_data;
      logic [31:0]     imm;
      logic [4:0]      rt;
      logic [4:0]      rd;
      logic [5:0]      funct;
      logic [25:0]     jtarget;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            alu_src;
      logic            illegal;
   } idex_t;

   idex_t       ex_q, ex_d;
   logic [31:0] regs_q [NREGS];

   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic [31:0] rs_val, rt_val;
   logic        uses_rt;
   logic        stall;

   assign instr   = bus.IF_ID[31:0];
   assign opcode  = instr[31:26];
   assign rs      = instr[25:21];
   assign rt      = instr[20:16];
   assign uses_rt = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);

   always_comb begin
      rs_val = (rs == 5'd0) ? 32'd0 : regs_q[rs];
      rt_val = (rt == 5'd0) ? 32'd0 : regs_q[rt];
`ifdef DECODE_WB_BYPASS_EN
      if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rs_val = bus.wb_data;
      if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rt_val = bus.wb_data;
`endif
   end

   // A load in ID/EX whose target feeds this instruction costs one bubble.
   assign stall = bus.if_valid && ex_q.valid && ex_q.mem_read && (ex_q.rt != 5'd0) &&
                  ((ex_q.rt == rs) || ((ex_q.rt == rt) && uses_rt)) && !bus.flush;

   always_comb begin
      ex_d = '0;
      if (bus.if_valid && !bus.flush && !stall) begin
         ex_d.valid   = 1'b1;
         ex_d.pc      = bus.IF_ID[PC_W+31:32];
         ex_d.rs_data = rs_val;
         ex_d.rt_data = rt_val;
         ex_d.imm     = {{16{instr[15]}}, instr[15:0]};
         ex_d.rt      = rt;
         ex_d.rd      = (opcode == OP_R) ? instr[15:11] : rt;
         ex_d.funct   = instr[5:0];
         ex_d.jtarget = instr[25:0];
         case (opcode)
            OP_R:    ex_d.reg_write = 1'b1;
            OP_ADDI: begin ex_d.reg_write = 1'b1; ex_d.alu_src = 1'b1; end
            OP_LW:   begin ex_d.reg_write = 1'b1; ex_d.mem_read = 1'b1; ex_d.alu_src = 1'b1; end
            OP_SW:   begin ex_d.mem_write = 1'b1; ex_d.alu_src = 1'b1; end
            OP_BEQ:  ex_d.branch = 1'b1;
            OP_J:    ex_d.jump = 1'b1;
            default: ex_d.illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
         regs_q[bus.wb_addr] <= bus.wb_data;
      end
   end

   assign bus.stall        = stall;
   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_rs_data   = ex_q.rs_data;
   assign bus.ex_rt_data   = ex_q.rt_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_rt        = ex_q.rt;
   assign bus.ex_rd        = ex_q.rd;
   assign bus.ex_funct     = ex_q.funct;
   assign bus.ex_jtarget   = ex_q.jtarget;
   assign bus.ex_reg_write = ex_q.reg_write;
   assign bus.ex_mem_read  = ex_q.mem_read;
   assign bus.ex_mem_write = ex_q.mem_write;
   assign bus.ex_branch    = ex_q.branch;
   assign bus.ex_jump      = ex_q.jump;
   assign bus.ex_alu_src   = ex_q.alu_src;
   assign bus.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - directed table-driven bench for decode
// Each row: inputs driven after negedge, stall checked before the edge, ID/EX checked after it.
module tb_decode;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   decode_if #(.PC_W(32)) bus ();

   decode dut (.clock(clock), .reset(reset), .bus(bus));

   // ctrl = {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_R    = 7'b1000000;
   localparam logic [6:0] C_ADDI = 7'b1000010;
   localparam logic [6:0] C_LW   = 7'b1100010;
   localparam logic [6:0] C_SW   = 7'b0010010;
   localparam logic [6:0] C_BEQ  = 7'b0001000;
   localparam logic [6:0] C_J    = 7'b0000100;
   localparam logic [6:0] C_ILL  = 7'b0000001;
`ifdef DECODE_WB_BYPASS_EN
   localparam logic [31:0] BYP = 32'hDEADBEEF;
`else
   localparam logic [31:0] BYP = 32'h0;
`endif

   typedef struct {
      logic [31:0] pc, instr;
      logic        v, fl, wbe;
      logic [4:0]  wba;
      logic [31:0] wbd;
      logic        st, ev;
      logic [31:0] rsd, rtd, imm;
      logic [4:0]  rt, rd;
      logic [6:0]  ctrl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] pc, instr, input logic v, fl, wbe,
                               input logic [4:0] wba, input logic [31:0] wbd,
                               input logic st, ev, input logic [31:0] rsd, rtd, imm,
                               input logic [4:0] rt, rd, input logic [6:0] ctrl);
      vec_t r;
      r.pc = pc; r.instr = instr; r.v = v; r.fl = fl; r.wbe = wbe; r.wba = wba; r.wbd = wbd;
      r.st = st; r.ev = ev; r.rsd = rsd; r.rtd = rtd; r.imm = imm; r.rt = rt; r.rd = rd;
      r.ctrl = ctrl;
      return r;
   endfunction

   function automatic vec_t bub(input logic [31:0] pc, instr, input logic v, fl, wbe,
                                input logic [4:0] wba, input logic [31:0] wbd, input logic st);
      return mk(pc, instr, v, fl, wbe, wba, wbd, st, 1'b0, 0, 0, 0, 5'd0, 5'd0, C_NONE);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] ctrl_act();
      return {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_branch,
              bus.ex_jump, bus.ex_alu_src, bus.ex_illegal};
   endfunction

   task automatic check_zero(input string tag);
      check({tag, " stall"}, 64'(bus.stall), 0);
      check({tag, " ex_valid"}, 64'(bus.ex_valid), 0);
      check({tag, " ex_pc"}, 64'(bus.ex_pc), 0);
      check({tag, " rs_data"}, 64'(bus.ex_rs_data), 0);
      check({tag, " rt_data"}, 64'(bus.ex_rt_data), 0);
      check({tag, " imm"}, 64'(bus.ex_imm), 0);
      check({tag, " rt/rd"}, 64'({bus.ex_rt, bus.ex_rd}), 0);
      check({tag, " funct/jt"}, 64'({bus.ex_funct, bus.ex_jtarget}), 0);
      check({tag, " ctrl"}, 64'(ctrl_act()), 0);
   endtask

   task automatic drive(input logic [31:0] pc, instr, input logic v, fl, wbe,
                        input logic [4:0] wba, input logic [31:0] wbd);
      bus.IF_ID = {pc, instr}; bus.if_valid = v; bus.flush = fl;
      bus.wb_en = wbe; bus.wb_addr = wba; bus.wb_data = wbd;
   endtask

   initial begin
      vec_t  r;
      string t;
      vecs.push_back(mk(32'h00, 32'h00011000, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h1000, 1, 2, C_R));
      vecs.push_back(bub(32'h00, 32'h0, 0, 0, 1, 5'd1, 32'h5, 0));
      vecs.push_back(bub(32'h00, 32'h0, 0, 0, 1, 5'd3, 32'h33, 0));
      vecs.push_back(mk(32'h04, 32'h2022FFFF, 1, 0, 0, 0, 0, 0, 1, 5, 0, 32'hFFFFFFFF, 2, 2, C_ADDI));
      vecs.push_back(mk(32'h08, 32'h8C230000, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 0, 3, 3, C_LW));
      vecs.push_back(bub(32'h0C, 32'h00612020, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h0C, 32'h00612020, 1, 0, 0, 0, 0, 0, 1, 32'h33, 5, 32'h2020, 1, 4, C_R));
      vecs.push_back(mk(32'h10, 32'h8C230000, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 0, 3, 3, C_LW));
      vecs.push_back(bub(32'h14, 32'h00612020, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(32'h14, 32'h00612020, 1, 0, 0, 0, 0, 0, 1, 32'h33, 5, 32'h2020, 1, 4, C_R));
      vecs.push_back(mk(32'h18, 32'h8C230000, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 0, 3, 3, C_LW));
      vecs.push_back(bub(32'h1C, 32'hAC230004, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(32'h1C, 32'hAC230004, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 4, 3, 3, C_SW));
      vecs.push_back(mk(32'h20, 32'h8C230000, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 0, 3, 3, C_LW));
      vecs.push_back(mk(32'h24, 32'h20230001, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 1, 3, 3, C_ADDI));
      vecs.push_back(mk(32'h28, 32'h10230008, 1, 0, 0, 0, 0, 0, 1, 5, 32'h33, 8, 3, 3, C_BEQ));
      vecs.push_back(mk(32'h2C, 32'h08000010, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h10, 0, 0, C_J));
      vecs.push_back(mk(32'h30, 32'hFC000000, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_ILL));
      vecs.push_back(bub(32'h00, 32'h0, 0, 0, 1, 5'd0, 32'h1, 0));
      vecs.push_back(mk(32'h34, 32'h20000001, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, C_ADDI));
      vecs.push_back(mk(32'h38, 32'h20E80000, 1, 0, 1, 5'd7, 32'hDEADBEEF, 0, 1, BYP, 0, 0, 8, 8, C_ADDI));
      vecs.push_back(mk(32'h3C, 32'h20E80000, 1, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 8, 8, C_ADDI));
      vecs.push_back(mk(32'h40, 32'h8C200000, 1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, C_LW));
      vecs.push_back(mk(32'h44, 32'h00000000, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_R));

      // Reset held with a valid instruction presented: nothing may leak through.
      drive(32'h0, 32'h00011000, 1, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1 check_zero("reset");
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("release ex_valid", 64'(bus.ex_valid), 1);
      check("release ex_pc", 64'(bus.ex_pc), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         r = vecs[i];
         @(negedge clock);
         drive(r.pc, r.instr, r.v, r.fl, r.wbe, r.wba, r.wbd);
         #1;
         t = $sformatf("row%0d", i);
         check({t, " stall"}, 64'(bus.stall), 64'(r.st));
         @(posedge clock);
         #1;
         check({t, " ex_valid"}, 64'(bus.ex_valid), 64'(r.ev));
         check({t, " ex_pc"}, 64'(bus.ex_pc), r.ev ? 64'(r.pc) : 0);
         check({t, " rs_data"}, 64'(bus.ex_rs_data), 64'(r.rsd));
         check({t, " rt_data"}, 64'(bus.ex_rt_data), 64'(r.rtd));
         check({t, " imm"}, 64'(bus.ex_imm), 64'(r.imm));
         check({t, " rt/rd"}, 64'({bus.ex_rt, bus.ex_rd}), 64'({r.rt, r.rd}));
         check({t, " funct/jt"}, 64'({bus.ex_funct, bus.ex_jtarget}),
               r.ev ? 64'({r.instr[5:0], r.instr[25:0]}) : 0);
         check({t, " ctrl"}, 64'(ctrl_act()), 64'(r.ctrl));
      end

      // Asynchronous reset mid-cycle with a valid instruction latched.
      @(negedge clock);
      drive(32'h48, 32'h8C230000, 1, 0, 0, 0, 0);
      @(posedge clock);
      #1 check("pre-reset ex_valid", 64'(bus.ex_valid), 1);
      #2 reset = 1'b0;
      #1 check_zero("async reset");
      @(negedge clock);
      drive(32'h50, 32'h2022FFFF, 1, 0, 0, 0, 0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("post-reset ex_valid", 64'(bus.ex_valid), 1);
      check("post-reset ex_pc", 64'(bus.ex_pc), 32'h50);
      check("post-reset r1 cleared", 64'(bus.ex_rs_data), 0);
      check("post-reset ctrl", 64'(ctrl_act()), 64'(C_ADDI));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
